minsoc_clkgen_seq: RTL and testbench
====================================

MINSOC_CLKGEN_SEQ -- requirements
Module: minsoc_clkgen_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of clock-enable channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of each half-period divider value.
REQ-003 SHALL have parameter RST_DELAY, default 2, cycles `rst_o` stays low before assertion.
REQ-004 SHALL have parameter RST_CYCLES, default 16, cycles `rst_o` is held high.
REQ-005 SHALL have parameter STAGGER, default 4, cycles between successive channel reset releases.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports:
- `clock`  input  1  sole clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  global divider enable.
- `div_half`  input  NUM_CH*CNT_W  per-channel half-period in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
- `sw_rst_req`  input  1  single-cycle request to re-run the reset sequence.
- `rst_o`  output  1  generated system reset, active-high.
- `rst_ch_o`  output  NUM_CH  per-channel reset, active-high.
- `clk_en_o`  output  NUM_CH  one-cycle strobe at each half-period boundary.
- `tgl_o`  output  NUM_CH  square wave toggling on each strobe.
- `seq_done`  output  1  high while in RUN.

Function
REQ-007 SHALL implement an FSM with states DELAY, ASSERT, RELEASE and RUN.
- DELAY: `rst_o`=0; after RST_DELAY cycles, go to ASSERT.
- ASSERT: `rst_o`=1; after RST_CYCLES cycles, go to RELEASE.
- RELEASE: `rst_o`=0; after the last channel is released, go to RUN.
REQ-008 SHALL hold all `rst_ch_o` bits high in DELAY and ASSERT.
REQ-009 SHALL, in RELEASE, deassert `rst_ch_o[i]` i*STAGGER cycles after the first RELEASE cycle; channel 0 deasserts in the same cycle `rst_o` falls.
REQ-010 SHALL enter RUN and assert `seq_done` the cycle after `rst_ch_o[NUM_CH-1]` deasserts.
REQ-011 SHALL, on `sw_rst_req`=1 in RUN, go to ASSERT next cycle, skipping DELAY, and reassert `rst_o` and all `rst_ch_o`.
REQ-012 SHALL ignore `sw_rst_req` outside RUN; it SHALL NOT be queued.
REQ-013 SHALL, per channel, hold its counter at 0 and `tgl_o[i]`=0 whenever `rst_ch_o[i]`=1 or `en`=0.
REQ-014 SHALL otherwise increment the counter each cycle.
REQ-015 SHALL detect a terminal count when counter >= eff-1, where eff = `div_half[i]`, or 1 if `div_half[i]`=0.
REQ-016 SHALL, on terminal count: pulse `clk_en_o[i]` for exactly one cycle, toggle `tgl_o[i]`, and reload the counter to 0.
REQ-017 SHALL, for `div_half`=0 or 1, strobe `clk_en_o[i]` every cycle, with `tgl_o[i]` toggling every cycle.
REQ-018 SHALL apply a `div_half` change mid-count immediately; because of the >= compare, lowering the value below the current count SHALL strobe on the next cycle and never wrap the counter.
REQ-019 SHALL keep `clk_en_o`, `tgl_o` and the counter at 0 on deassertion of `en`, and restart counting from 0 when `en` is reasserted.
REQ-020 SHALL keep divider counters free of overflow for all CNT_W-bit `div_half` values.
REQ-021 SHALL NOT depend on input ordering when `sw_rst_req` and `en` change in the same cycle; the FSM transition and the divider hold are evaluated independently.

Reset
REQ-022 SHALL, while `reset`=1 at a rising edge, set the state to DELAY and the following reset values:
- `rst_o`=0
- `rst_ch_o`=all ones
- `clk_en_o`=0
- `tgl_o`=0
- `seq_done`=0
- all counters = 0
REQ-023 SHALL, on `reset` asserted mid-sequence or in RUN, abort and restart from DELAY the cycle after `reset` deasserts.

Configuration
REQ-024 SHALL, with macro MINSOC_CLKGEN_STAGGER_EN defined, release channel resets staggered as in REQ-009.
REQ-025 SHALL, with MINSOC_CLKGEN_STAGGER_EN undefined, deassert all `rst_ch_o` in the cycle `rst_o` falls, and leave RELEASE after one cycle; the STAGGER parameter SHALL then be unused.

Structure
REQ-026 SHALL take the FSM state encoding (2-bit), state localparams and default parameter values from shared package minsoc_clkgen_pkg.
REQ-027 SHALL implement the per-channel divider (counter, compare, strobe, toggle) as sub-module minsoc_clkgen_div, instantiated NUM_CH times via generate.

Verification
REQ-028 SHALL cover the following directed scenarios:
- Defaults, `reset` released at cycle 0 -> `rst_o` low at cycles 0-1, high at cycles 2-17, low from 18; `rst_ch_o[0]` falls at 18, `rst_ch_o[1]` at 22; `seq_done` high from 23.
- `div_half`={ch1=5, ch0=2}, `en`=1 after release -> `clk_en_o[0]` every 2 cycles, `clk_en_o[1]` every 5 cycles; `tgl_o` periods 4 and 10 cycles.
- ch0 `div_half`=0 -> strobe every cycle; change ch1 from 200 to 3 when its count is 50 -> strobe next cycle, then every 3 cycles.
- `sw_rst_req` pulse in RUN -> `rst_o` high the next cycle for 16 cycles, no DELAY phase; pulse during ASSERT -> no effect, no extra cycles.
- `reset` asserted at cycle 10 (in ASSERT) -> all outputs at reset values; sequence restarts with a 2-cycle DELAY.
- MINSOC_CLKGEN_STAGGER_EN undefined -> both `rst_ch_o` bits fall at cycle 18; `seq_done` high at cycle 19.

Source files
------------

// File: rtl/minsoc_clkgen_pkg.sv
// Shared definitions for the minsoc clock-enable / reset sequencer:
// default parameter values, 2-bit sequencer state encoding and a small
// sizing helper.
package minsoc_clkgen_pkg;

   localparam int unsigned DEF_NUM_CH     = 2;
   localparam int unsigned DEF_CNT_W      = 8;
   localparam int unsigned DEF_RST_DELAY  = 2;
   localparam int unsigned DEF_RST_CYCLES = 16;
   localparam int unsigned DEF_STAGGER    = 4;

   localparam logic [1:0] ST_DELAY   = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_RUN     = 2'd3;

   typedef enum logic [1:0] {
      S_DELAY   = ST_DELAY,
      S_ASSERT  = ST_ASSERT,
      S_RELEASE = ST_RELEASE,
      S_RUN     = ST_RUN
   } seq_state_e;

   // Largest of three cycle counts, used to size the sequencer counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/minsoc_clkgen_div.sv
// One clock-enable channel: a half-period counter that strobes clk_en_o
// and flips tgl_o each time it reaches the programmed half period.
// A zero half period behaves like one (strobe every cycle).
module minsoc_clkgen_div
   import minsoc_clkgen_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             hold_i,
   input  logic [CNT_W-1:0] div_half_i,
   output logic             clk_en_o,
   output logic             tgl_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] eff;
   logic             clk_en_q, clk_en_d;
   logic             tgl_q, tgl_d;
   logic             tc;

   assign eff = (div_half_i == '0) ? CNT_W'(1) : div_half_i;
   // ">=" rather than "==" so a shrinking half period strobes at once
   // instead of letting the counter run on and wrap.
   assign tc  = (cnt_q >= (eff - CNT_W'(1)));

   // Next-state: reload and strobe on terminal count, else count up.
   always_comb begin
      cnt_d    = cnt_q + CNT_W'(1);
      clk_en_d = 1'b0;
      tgl_d    = tgl_q;
      if (tc) begin
         cnt_d    = '0;
         clk_en_d = 1'b1;
         tgl_d    = ~tgl_q;
      end
   end

   // Registers; held at zero while the channel is in reset or disabled.
   always_ff @(posedge clk_i) begin
      if (reset_i || hold_i) begin
         cnt_q    <= '0;
         clk_en_q <= 1'b0;
         tgl_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         clk_en_q <= clk_en_d;
         tgl_q    <= tgl_d;
      end
   end

   assign clk_en_o = clk_en_q;
   assign tgl_o    = tgl_q;

endmodule

// File: rtl/minsoc_clkgen_seq.sv
// minsoc reset sequencer and clock-enable generator.
// Sequence: DELAY (rst_o low) -> ASSERT (rst_o high) -> RELEASE (channel
// resets dropped) -> RUN. A software request in RUN re-enters ASSERT.
// Optional feature macro MINSOC_CLKGEN_STAGGER_EN: when defined, channel
// i leaves reset i*STAGGER cycles after channel 0; otherwise all channels
// leave reset together and RELEASE lasts a single cycle.
module minsoc_clkgen_seq
   import minsoc_clkgen_pkg::*;
#(
   parameter int unsigned NUM_CH     = DEF_NUM_CH,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned RST_DELAY  = DEF_RST_DELAY,
   parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
   parameter int unsigned STAGGER    = DEF_STAGGER
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    en,
   input  logic [NUM_CH*CNT_W-1:0] div_half,
   input  logic                    sw_rst_req,
   output logic                    rst_o,
   output logic [NUM_CH-1:0]       rst_ch_o,
   output logic [NUM_CH-1:0]       clk_en_o,
   output logic [NUM_CH-1:0]       tgl_o,
   output logic                    seq_done
);

`ifdef MINSOC_CLKGEN_STAGGER_EN
   localparam int unsigned STG = STAGGER;
`else
   localparam int unsigned STG = 0;
`endif
   // Cycle index within RELEASE at which the last channel is let go.
   localparam int unsigned REL_LAST = (NUM_CH - 1) * STG;
   // Counter sized for the longest phase (stagger span included either way).
   localparam int unsigned SEQ_MAX  = max3(RST_DELAY, RST_CYCLES, (NUM_CH - 1) * STAGGER);
   localparam int unsigned SEQ_W    = $clog2(SEQ_MAX + 2);

   seq_state_e        state_q;
   logic [SEQ_W-1:0]  cnt_q;
   logic [31:0]       nxt_cnt;
   logic              rst_q;
   logic [NUM_CH-1:0] rst_ch_q;
   logic              done_q;
   logic [NUM_CH-1:0] rel_first;
   logic [NUM_CH-1:0] rel_keep;

   assign nxt_cnt = 32'(cnt_q) + 32'd1;

   // Channel reset masks: for the first RELEASE cycle, and for the cycle
   // after the current one while RELEASE continues.
   always_comb begin
      rel_first = '0;
      rel_keep  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rel_first[i] = (32'(i) * STG) > 32'd0;
         rel_keep[i]  = (32'(i) * STG) > nxt_cnt;
      end
   end

   // Sequencer FSM with registered reset/done outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_DELAY;
         cnt_q    <= '0;
         rst_q    <= 1'b0;
         rst_ch_q <= '1;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_DELAY: begin
               if (nxt_cnt >= RST_DELAY) begin
                  state_q <= S_ASSERT;
                  cnt_q   <= '0;
                  rst_q   <= 1'b1;
               end else begin
                  cnt_q   <= SEQ_W'(nxt_cnt);
               end
            end
            S_ASSERT: begin
               if (nxt_cnt >= RST_CYCLES) begin
                  state_q  <= S_RELEASE;
                  cnt_q    <= '0;
                  rst_q    <= 1'b0;
                  rst_ch_q <= rel_first;
               end else begin
                  cnt_q    <= SEQ_W'(nxt_cnt);
               end
            end
            S_RELEASE: begin
               if (32'(cnt_q) >= REL_LAST) begin
                  state_q  <= S_RUN;
                  cnt_q    <= '0;
                  rst_ch_q <= '0;
                  done_q   <= 1'b1;
               end else begin
                  cnt_q    <= SEQ_W'(nxt_cnt);
                  rst_ch_q <= rel_keep;
               end
            end
            S_RUN: begin
               // Software re-reset skips DELAY; requests elsewhere are dropped.
               if (sw_rst_req) begin
                  state_q  <= S_ASSERT;
                  cnt_q    <= '0;
                  rst_q    <= 1'b1;
                  rst_ch_q <= '1;
                  done_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_DELAY;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Per-channel dividers; each is held while its channel reset is high
   // or the global enable is low.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      minsoc_clkgen_div #(
         .CNT_W (CNT_W)
      ) u_div (
         .clk_i      (clock),
         .reset_i    (reset),
         .hold_i     (rst_ch_q[g] | ~en),
         .div_half_i (div_half[g*CNT_W +: CNT_W]),
         .clk_en_o   (clk_en_o[g]),
         .tgl_o      (tgl_o[g])
      );
   end

   assign rst_o    = rst_q;
   assign rst_ch_o = rst_ch_q;
   assign seq_done = done_q;

endmodule

// File: tb/tb_minsoc_clkgen_seq.sv
// Self-checking bench for minsoc_clkgen_seq (default parameters).
// Expected values come from closed-form cycle formulas, queued per cycle
// and popped when the outputs are sampled on the falling edge.
module tb_minsoc_clkgen_seq;

`ifdef MINSOC_CLKGEN_STAGGER_EN
   localparam int STG = 4;
`else
   localparam int STG = 0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [15:0] div_half = '0;
   logic        sw_rst_req = 1'b0;
   logic        rst_o;
   logic [1:0]  rst_ch_o;
   logic [1:0]  clk_en_o;
   logic [1:0]  tgl_o;
   logic        seq_done;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic       rst;
      logic [1:0] ch;
      logic       done;
   } seq_t;

   typedef struct packed {
      logic [1:0] ce;
      logic [1:0] tg;
   } dexp_t;

   seq_t  seq_q[$];
   dexp_t div_q[$];

   minsoc_clkgen_seq dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .div_half   (div_half),
      .sw_rst_req (sw_rst_req),
      .rst_o      (rst_o),
      .rst_ch_o   (rst_ch_o),
      .clk_en_o   (clk_en_o),
      .tgl_o      (tgl_o),
      .seq_done   (seq_done)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Power-on sequence expectation, c = cycles since reset released.
   function automatic seq_t seq_exp(input int c);
      seq_t e;
      e.rst   = (c >= 2) && (c <= 17);
      e.ch[0] = (c < 18);
      e.ch[1] = (c < 18 + STG);
      e.done  = (c >= 19 + STG);
      return e;
   endfunction

   // Caller stands in cycle 0 (just after the releasing edge).
   task automatic run_seq(input int ncyc, input string name);
      seq_t got, e;
      for (int c = 0; c < ncyc; c++) begin
         seq_q.push_back(seq_exp(c));
         @(negedge clock);
         got = {rst_o, rst_ch_o, seq_done};
         e = seq_q.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL %s cycle %0d got rst/ch/done=%b want %b", name, c, got, e);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b1;
      div_half = {8'd1, 8'd1};
      tick(); tick(); tick();
      @(negedge clock);
      checks++;
      if ({rst_o, rst_ch_o, seq_done} !== 4'b0110) begin
         failures++;
         $display("FAIL reset_seq got %b want 0110", {rst_o, rst_ch_o, seq_done});
      end
      checks++;
      if (clk_en_o !== 2'b00) begin
         failures++;
         $display("FAIL reset_clk_en got %b want 00", clk_en_o);
      end
      checks++;
      if (tgl_o !== 2'b00) begin
         failures++;
         $display("FAIL reset_tgl got %b want 00", tgl_o);
      end
      en = 1'b0;
      tick();
   endtask

   task automatic test_sequence();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      run_seq(32, "power_on_seq");
   endtask

   task automatic test_divider();
      dexp_t e, got;
      div_half = {8'd5, 8'd2};
      en = 1'b1;
      for (int k = 0; k < 40; k++) begin
         e.ce[0] = (k > 0) && (k % 2 == 0);
         e.tg[0] = ((k / 2) % 2) == 1;
         e.ce[1] = (k > 0) && (k % 5 == 0);
         e.tg[1] = ((k / 5) % 2) == 1;
         div_q.push_back(e);
         @(negedge clock);
         got = {clk_en_o, tgl_o};
         e = div_q.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL div_5_2 k=%0d got ce/tgl=%b want %b", k, got, e);
         end
         tick();
      end
      en = 1'b0;
      tick();
      @(negedge clock);
      checks++;
      if ({clk_en_o, tgl_o} !== 4'b0000) begin
         failures++;
         $display("FAIL en_low_hold got ce/tgl=%b want 0000", {clk_en_o, tgl_o});
      end
      tick();
   endtask

   task automatic test_div_change();
      dexp_t e, got;
      int n;
      div_half = {8'd200, 8'd0};
      en = 1'b1;
      for (int k = 0; k < 66; k++) begin
         if (k == 50) div_half[15:8] = 8'd3;
         n = (k >= 51) ? 1 + (k - 51) / 3 : 0;
         e.ce[0] = (k > 0);
         e.tg[0] = (k % 2) == 1;
         e.ce[1] = (k >= 51) && ((k - 51) % 3 == 0);
         e.tg[1] = (n % 2) == 1;
         div_q.push_back(e);
         @(negedge clock);
         got = {clk_en_o, tgl_o};
         e = div_q.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL div_change k=%0d got ce/tgl=%b want %b", k, got, e);
         end
         tick();
      end
      en = 1'b0;
      tick();
   endtask

   task automatic test_sw_rst();
      seq_t e, got;
      sw_rst_req = 1'b1;
      for (int r = 0; r < 32; r++) begin
         if (r == 1) sw_rst_req = 1'b0;
         if (r == 5) sw_rst_req = 1'b1;
         if (r == 6) sw_rst_req = 1'b0;
         e.rst   = (r >= 1) && (r <= 16);
         e.ch[0] = (r >= 1) && (r <= 16);
         e.ch[1] = (r >= 1) && (r <= 16 + STG);
         e.done  = (r == 0) || (r >= 18 + STG);
         seq_q.push_back(e);
         @(negedge clock);
         got = {rst_o, rst_ch_o, seq_done};
         e = seq_q.pop_front();
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL sw_rst r=%0d got rst/ch/done=%b want %b", r, got, e);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      run_seq(10, "pre_abort_seq");
      reset = 1'b1;
      en = 1'b1;
      div_half = {8'd1, 8'd0};
      tick();
      @(negedge clock);
      checks++;
      if ({rst_o, rst_ch_o, seq_done, clk_en_o, tgl_o} !== 8'b0110_0000) begin
         failures++;
         $display("FAIL mid_reset got rst/ch/done/ce/tgl=%b want 01100000",
                  {rst_o, rst_ch_o, seq_done, clk_en_o, tgl_o});
      end
      tick();
      reset = 1'b0;
      run_seq(26, "restart_seq");
      en = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_divider();
      test_div_change();
      test_sw_rst();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
